// File: rtl/shift_add_mult32_ctrl_if.sv
// Request/response bundle between the ALU and the shift-add multiplier sequencer.
interface shift_add_mult32_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mult32_ctrl.sv
// Unsigned shift-and-add multiplier that borrows the ALU's WIDTH-bit adder:
// one partial-product add and right shift per RUN cycle, WIDTH cycles per product.
module shift_add_mult32_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_mult32_ctrl_if.slave bus,
  output logic [WIDTH-1:0]     add_x_o,
  output logic [WIDTH-1:0]     add_y_o,
  output logic                 add_cin_o,
  input  logic [WIDTH-1:0]     add_s_i,
  input  logic                 add_cout_i
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    count_d   = count_q;
    product_d = product_q;
    add_x_o   = '0;
    add_y_o   = '0;
    add_cin_o = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          m_d     = bus.a;
          p_d     = {{WIDTH{1'b0}}, bus.b};
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        add_x_o = p_q[2*WIDTH-1:WIDTH];
        add_y_o = p_q[0] ? m_q : '0;
        // Adder carry becomes the new MSB, so the 2W+1-bit shift loses nothing.
        p_d     = {add_cout_i, add_s_i, p_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d   = S_DONE;
          product_d = p_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult32_ctrl.sv
// Scoreboard bench for shift_add_mult32_ctrl: directed operands with
// hand-computed products, checked by an independent done monitor.
module tb_shift_add_mult32_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  add_x, add_y, add_s;
  logic          add_cin, add_cout;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int busy_run = 0;
  bit prev_done = 1'b0;
  logic [2*W-1:0] exp_q[$];

  shift_add_mult32_ctrl_if #(.WIDTH(W)) bus ();

  shift_add_mult32_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .add_x_o    (add_x),
    .add_y_o    (add_y),
    .add_cin_o  (add_cin),
    .add_s_i    (add_s),
    .add_cout_i (add_cout)
  );

  // Stand-in for ripple_adder32: plain 33-bit sum of the adder ports.
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks pulse shape.
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy && bus.done) chk("busy_and_done", 64'd1, 64'd0);
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          chk("product", bus.product, exp_q.pop_front());
          chk("busy_len", 64'(busy_run), 64'd32);
        end
        if (prev_done) chk("done_width", 64'd2, 64'd1);
        busy_run = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        return;
      end
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    bit ok;
    exp_q.push_back(exp);
    issue(a, b);
    wait_done(ok);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int t0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk("idle_add_x", 64'(add_x), 64'd0);

    run_op(32'd3, 32'd5, 64'd15);
    chk("idle_add_y", 64'(add_y), 64'd0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op(32'h12345678, 32'd0, 64'd0);
    run_op(32'd0, 32'hDEADBEEF, 64'd0);
    run_op(32'h80000000, 32'd2, 64'h00000001_00000000);

    // Start pulsed mid-run must be ignored.
    exp_q.push_back(64'd42);
    issue(32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1 bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1 bus.start = 1'b0; bus.a = '0; bus.b = '0;
    wait_done(ok);
    repeat (40) @(negedge clk);
    chk("held_product", bus.product, 64'd42);

    // Reset mid-run aborts: no done, product cleared.
    issue(32'd100, 32'd200);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_product", bus.product, 64'd0);
    repeat (40) @(negedge clk);
    run_op(32'd2, 32'd3, 64'd6);

    // Continuous start: back-to-back products, DONE goes straight to RUN.
    repeat (3) exp_q.push_back(64'd110);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd10; bus.b = 32'd11;
    wait_done(ok);
    t0 = cycle;
    @(negedge clk);
    chk("done_to_run", 64'(bus.busy), 64'd1);
    wait_done(ok);
    chk("period", 64'(cycle - t0), 64'd33);
    t0 = cycle;
    wait_done(ok);
    chk("period2", 64'(cycle - t0), 64'd33);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
